// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage and an external requester.
// Optional DMEM_ARB_PERF_EN adds stall and EXT-grant performance counters.
module dmem_port_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [DATA_WIDTH-1:0] ext_wdata,
  output logic                  ext_ack,
  output logic [DATA_WIDTH-1:0] ext_rdata,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]           perf_cpu_stall_cnt,
  output logic [31:0]           perf_ext_grant_cnt
`endif
);

  typedef enum logic [0:0] {StIdle, StRdWait} state_e;

  localparam logic [1:0] LatInit   = 2'(READ_LATENCY - 1);
  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic       owner_q, owner_d;  // 1 = EXT owns the in-flight read
  logic [1:0] lat_q, lat_d;
  logic [3:0] starve_q, starve_d;

  logic ext_win, cpu_win, issue, ext_sel, issue_we, ext_issue;

  assign ext_win   = ext_req && (starve_q == StarveMax);
  assign cpu_win   = cpu_req && !ext_win;
  // Issue is suppressed while reset is asserted so nothing reaches memory during reset.
  assign issue     = (state_q == StIdle) && !reset && (cpu_win || ext_req);
  assign ext_sel   = !cpu_win;
  assign issue_we  = ext_sel ? ext_we : cpu_we;
  assign ext_issue = issue && ext_sel;

  assign starve_d = (!ext_req || ext_issue) ? 4'd0 :
                    (starve_q == StarveMax) ? starve_q : starve_q + 4'd1;

  assign cpu_stall = cpu_req & ~cpu_ack;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    lat_d     = lat_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_ack   = 1'b0;
    ext_ack   = 1'b0;
    cpu_rdata = '0;
    ext_rdata = '0;
    case (state_q)
      StIdle: begin
        if (issue) begin
          mem_addr = ext_sel ? ext_addr : cpu_addr;
          if (issue_we) begin
            mem_we    = 1'b1;
            mem_wdata = ext_sel ? ext_wdata : cpu_wdata;
            cpu_ack   = !ext_sel;
            ext_ack   = ext_sel;
          end else begin
            mem_re  = 1'b1;
            owner_d = ext_sel;
            lat_d   = LatInit;
            state_d = StRdWait;
          end
        end
      end
      StRdWait: begin
        // A read pending at reset is dropped without an ack.
        if (!reset) begin
          if (lat_q == 2'd0) begin
            cpu_ack   = !owner_q;
            ext_ack   = owner_q;
            cpu_rdata = owner_q ? '0 : mem_rdata;
            ext_rdata = owner_q ? mem_rdata : '0;
            state_d   = StIdle;
          end else begin
            lat_d = lat_q - 2'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      lat_q    <= 2'd0;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] stall_cnt_q, grant_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      grant_cnt_q <= 32'd0;
    end else begin
      if (cpu_stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (ext_issue && (grant_cnt_q != 32'hFFFF_FFFF)) grant_cnt_q <= grant_cnt_q + 32'd1;
    end
  end

  assign perf_cpu_stall_cnt = stall_cnt_q;
  assign perf_ext_grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: three instances (READ_LATENCY 1/2/3) share stimulus; each
// vector checks one of them against table expectations and a read-data scoreboard.
module tb_dmem_port_arbiter;
  localparam int NI = 3;

  typedef struct {
    string       name;
    int          sel;
    bit          rst;
    bit          creq, cwe;
    logic [31:0] caddr, cwd;
    bit          ereq, ewe;
    logic [31:0] eaddr, ewd;
    bit          xwe, xre, xown, xcack, xeack, xstall;
  } vec_t;

  typedef struct {
    bit          own;
    logic [31:0] data;
  } rd_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, ext_req, ext_we;
  logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;

  logic        cpu_ack_w [NI];
  logic        cpu_stall_w [NI];
  logic        ext_ack_w [NI];
  logic        mem_we_w [NI];
  logic        mem_re_w [NI];
  logic [31:0] cpu_rdata_w [NI];
  logic [31:0] ext_rdata_w [NI];
  logic [31:0] mem_addr_w [NI];
  logic [31:0] mem_wdata_w [NI];
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_w [NI];
  logic [31:0] perf_grant_w [NI];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [31:0] mem [256];
    logic [31:0] hold;

    // Read data is captured at issue and held; it stays valid until the ack cycle.
    always @(posedge clk) begin
      if (mem_we_w[g]) mem[mem_addr_w[g][7:0]] <= mem_wdata_w[g];
      if (mem_re_w[g]) hold <= mem[mem_addr_w[g][7:0]];
    end

    dmem_port_arbiter #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (32),
      .READ_LATENCY(g + 1),
      .STARVE_LIMIT(4)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .cpu_req  (cpu_req),
      .cpu_we   (cpu_we),
      .cpu_addr (cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_ack  (cpu_ack_w[g]),
      .cpu_rdata(cpu_rdata_w[g]),
      .cpu_stall(cpu_stall_w[g]),
      .ext_req  (ext_req),
      .ext_we   (ext_we),
      .ext_addr (ext_addr),
      .ext_wdata(ext_wdata),
      .ext_ack  (ext_ack_w[g]),
      .ext_rdata(ext_rdata_w[g]),
      .mem_we   (mem_we_w[g]),
      .mem_re   (mem_re_w[g]),
      .mem_addr (mem_addr_w[g]),
      .mem_wdata(mem_wdata_w[g]),
      .mem_rdata(hold)
`ifdef DMEM_ARB_PERF_EN
      ,
      .perf_cpu_stall_cnt(perf_stall_w[g]),
      .perf_ext_grant_cnt(perf_grant_w[g])
`endif
    );
  end

  int          n_chk = 0;
  int          n_err = 0;
  rd_t         sb[$];
  logic [31:0] ref_mem [256];
  vec_t        tbl[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // x = {xwe, xre, xown, xcack, xeack, xstall}
  function automatic vec_t mk(string n, int sel, bit rst, bit creq, bit cwe,
                              logic [31:0] caddr, logic [31:0] cwd, bit ereq, bit ewe,
                              logic [31:0] eaddr, logic [31:0] ewd, logic [5:0] x);
    vec_t m;
    m.name = n; m.sel = sel; m.rst = rst;
    m.creq = creq; m.cwe = cwe; m.caddr = caddr; m.cwd = cwd;
    m.ereq = ereq; m.ewe = ewe; m.eaddr = eaddr; m.ewd = ewd;
    {m.xwe, m.xre, m.xown, m.xcack, m.xeack, m.xstall} = x;
    return m;
  endfunction

  task automatic run_vec(vec_t v);
    int          s;
    rd_t         e;
    logic [31:0] xa, xw;
    s         = v.sel;
    reset     = v.rst;
    cpu_req   = v.creq;
    cpu_we    = v.cwe;
    cpu_addr  = v.caddr;
    cpu_wdata = v.cwd;
    ext_req   = v.ereq;
    ext_we    = v.ewe;
    ext_addr  = v.eaddr;
    ext_wdata = v.ewd;
    xa = v.xown ? v.eaddr : v.caddr;
    xw = v.xown ? v.ewd : v.cwd;
    if (v.rst) sb.delete();
    if (v.xre) begin
      e.own  = v.xown;
      e.data = ref_mem[xa[7:0]];
      sb.push_back(e);
    end
    if (v.xwe) ref_mem[xa[7:0]] = xw;
    @(negedge clk);
    chk({v.name, ".mem_we"}, 32'(mem_we_w[s]), 32'(v.xwe));
    chk({v.name, ".mem_re"}, 32'(mem_re_w[s]), 32'(v.xre));
    chk({v.name, ".cpu_ack"}, 32'(cpu_ack_w[s]), 32'(v.xcack));
    chk({v.name, ".ext_ack"}, 32'(ext_ack_w[s]), 32'(v.xeack));
    chk({v.name, ".cpu_stall"}, 32'(cpu_stall_w[s]), 32'(v.xstall));
    if (v.xwe || v.xre) chk({v.name, ".mem_addr"}, mem_addr_w[s], xa);
    if (v.xwe) chk({v.name, ".mem_wdata"}, mem_wdata_w[s], xw);
    if (v.rst) begin
      chk({v.name, ".cpu_rdata"}, cpu_rdata_w[s], 32'h0);
      chk({v.name, ".ext_rdata"}, ext_rdata_w[s], 32'h0);
      chk({v.name, ".mem_addr"}, mem_addr_w[s], 32'h0);
      chk({v.name, ".mem_wdata"}, mem_wdata_w[s], 32'h0);
    end
    if ((v.xcack || v.xeack) && !v.xwe) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL %s.sb: read ack with no pending read", v.name);
      end else begin
        e = sb.pop_front();
        if (e.own) begin
          chk({v.name, ".ext_rdata"}, ext_rdata_w[s], e.data);
          chk({v.name, ".cpu_rdata"}, cpu_rdata_w[s], 32'h0);
        end else begin
          chk({v.name, ".cpu_rdata"}, cpu_rdata_w[s], e.data);
          chk({v.name, ".ext_rdata"}, ext_rdata_w[s], 32'h0);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;

    // Write then read back at READ_LATENCY=1.
    tbl.push_back(mk("s1_rst", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000));
    tbl.push_back(mk("s1_wr", 0, 0, 1, 1, 32'h10, 32'hCAFE, 0, 0, 0, 0, 6'b100100));
    tbl.push_back(mk("s1_rd_iss", 0, 0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 6'b010001));
    tbl.push_back(mk("s1_rd_ack", 0, 0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 6'b000100));
    tbl.push_back(mk("s1_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000));
    // READ_LATENCY=3 read: three stall cycles, ack on the third after issue.
    tbl.push_back(mk("s2_rst", 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000));
    tbl.push_back(mk("s2_wr", 2, 0, 1, 1, 32'h20, 32'h1234, 0, 0, 0, 0, 6'b100100));
    tbl.push_back(mk("s2_rd_iss", 2, 0, 1, 0, 32'h20, 0, 0, 0, 0, 0, 6'b010001));
    tbl.push_back(mk("s2_wait1", 2, 0, 1, 0, 32'h20, 0, 0, 0, 0, 0, 6'b000001));
    tbl.push_back(mk("s2_wait2", 2, 0, 1, 0, 32'h20, 0, 0, 0, 0, 0, 6'b000001));
    tbl.push_back(mk("s2_rd_ack", 2, 0, 1, 0, 32'h20, 0, 0, 0, 0, 0, 6'b000100));
    tbl.push_back(mk("s2_idle", 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000));
    // READ_LATENCY=2 EXT read in flight (EXT drops its request), CPU waits, then reads.
    tbl.push_back(mk("s4_rst", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000));
    tbl.push_back(mk("s4_ext_wr", 1, 0, 0, 0, 0, 0, 1, 1, 32'h30, 32'hBEEF, 6'b101010));
    tbl.push_back(mk("s4_ext_rd", 1, 0, 0, 0, 0, 0, 1, 0, 32'h30, 0, 6'b011000));
    tbl.push_back(mk("s4_cpu_wait", 1, 0, 1, 0, 32'h30, 0, 0, 0, 0, 0, 6'b000001));
    tbl.push_back(mk("s4_ext_ack", 1, 0, 1, 0, 32'h30, 0, 0, 0, 0, 0, 6'b000011));
    tbl.push_back(mk("s4_cpu_iss", 1, 0, 1, 0, 32'h30, 0, 0, 0, 0, 0, 6'b010001));
    tbl.push_back(mk("s4_cpu_wait2", 1, 0, 1, 0, 32'h30, 0, 0, 0, 0, 0, 6'b000001));
    tbl.push_back(mk("s4_cpu_ack", 1, 0, 1, 0, 32'h30, 0, 0, 0, 0, 0, 6'b000100));

    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
    @(posedge clk);
    #1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Starvation: EXT waits four cycles behind back-to-back CPU writes, wins the fifth.
    run_vec(mk("s3_rst", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000));
    for (int k = 0; k < 4; k++)
      run_vec(mk($sformatf("s3_cpu_wr%0d", k), 0, 0, 1, 1, 32'h40 + 32'(4 * k),
                 32'hA0 + 32'(k), 1, 1, 32'h80, 32'hE0, 6'b100100));
    run_vec(mk("s3_ext_win", 0, 0, 1, 1, 32'h50, 32'hA4, 1, 1, 32'h80, 32'hE0, 6'b101011));
    run_vec(mk("s3_cpu_wr4", 0, 0, 1, 1, 32'h50, 32'hA4, 0, 0, 0, 0, 6'b100100));
    run_vec(mk("s3_cpu_pri", 0, 0, 1, 1, 32'h54, 32'hA5, 1, 1, 32'h84, 32'hE1, 6'b100100));
`ifdef DMEM_ARB_PERF_EN
    chk("s6_perf_grant", perf_grant_w[0], 32'd1);
    chk("s6_perf_stall", perf_stall_w[0], 32'd1);
`endif

    // Reset during a READ_LATENCY=3 wait discards the pending ack.
    run_vec(mk("s5_rst", 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000));
    run_vec(mk("s5_rd_iss", 2, 0, 1, 0, 32'h20, 0, 0, 0, 0, 0, 6'b010001));
    run_vec(mk("s5_wait1", 2, 0, 1, 0, 32'h20, 0, 0, 0, 0, 0, 6'b000001));
    run_vec(mk("s5_mid_rst", 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000));
    run_vec(mk("s5_no_ack", 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000));
    run_vec(mk("s5_wr", 2, 0, 1, 1, 32'h24, 32'h77, 0, 0, 0, 0, 6'b100100));
    run_vec(mk("s5_idle", 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
